// File: rtl/ad_ip_jesd204_tpl_dac_channel_src_if.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_channel_src_if
// DMA beat handshake into the per-channel DAC sample source.
//   dma_valid  : DMA beat valid (driven by the DMA side)
//   dma_data   : DATA_PATH_WIDTH samples, 16 bits each, sample 0 in LSBs
//   dma_ready  : beat accepted this cycle when high together with dma_valid
// Modports: master = DMA side, slave = sample source.
// ---------------------------------------------------------------------------
interface ad_ip_jesd204_tpl_dac_channel_src_if #(
    parameter int unsigned DATA_PATH_WIDTH = 4
);
    localparam int unsigned DW = 16 * DATA_PATH_WIDTH;

    logic          dma_valid;
    logic [DW-1:0] dma_data;
    logic          dma_ready;

    modport master (output dma_valid, output dma_data, input  dma_ready);
    modport slave  (input  dma_valid, input  dma_data, output dma_ready);
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_channel_src.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_channel_src
// Per-channel DAC sample source in the link_clk domain. Selects one of DDS,
// alternating pattern, DMA, zero, PN7, PN15 or ramp and emits one registered
// beat of DATA_PATH_WIDTH 16-bit samples per cycle for the JESD framer.
// Ports:
//   link_clk, link_resetn      clock, async active-low reset
//   dac_data_sel [3:0]         source select from regmap
//   dac_dds_format             1 = invert MSB of DDS samples
//   dac_pat_data_0/1 [15:0]    pattern words for even/odd samples
//   dds_data                   DDS beat, sample 0 in LSBs
//   dma (slave modport)        DMA beat handshake
//   dac_data                   output beat, sample 0 in LSBs
//   dac_dunf                   one-cycle DMA underflow pulse
// Build option: define AD_TPL_DAC_SRC_RAMP_EN to include the ramp source
// (select code 11); without it code 11 outputs zero.
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_channel_src #(
    parameter  int unsigned DATA_PATH_WIDTH      = 4,
    parameter  int unsigned CONVERTER_RESOLUTION = 16,
    localparam int unsigned SW                   = 16,
    localparam int unsigned DW                   = SW * DATA_PATH_WIDTH
) (
    input  logic                    link_clk,
    input  logic                    link_resetn,
    input  logic [3:0]              dac_data_sel,
    input  logic                    dac_dds_format,
    input  logic [SW-1:0]           dac_pat_data_0,
    input  logic [SW-1:0]           dac_pat_data_1,
    input  logic [DW-1:0]           dds_data,
    ad_ip_jesd204_tpl_dac_channel_src_if.slave dma,
    output logic [DW-1:0]           dac_data,
    output logic                    dac_dunf
);

    localparam logic [3:0] SEL_DDS  = 4'd0;
    localparam logic [3:0] SEL_PAT  = 4'd1;
    localparam logic [3:0] SEL_DMA  = 4'd2;
    localparam logic [3:0] SEL_ZERO = 4'd3;
    localparam logic [3:0] SEL_PN7  = 4'd4;
    localparam logic [3:0] SEL_PN15 = 4'd5;
    localparam logic [3:0] SEL_RAMP = 4'd11;

    // Elaboration-time parameter sanity checks
    if (CONVERTER_RESOLUTION != 16) begin : g_res_chk
        $error("CONVERTER_RESOLUTION must be 16");
    end
    if ((DATA_PATH_WIDTH < 2) || (DATA_PATH_WIDTH % 2 != 0)) begin : g_dpw_chk
        $error("DATA_PATH_WIDTH must be even and >= 2");
    end

    logic [3:0]    sel_q;
    logic          dma_ready_q;
    logic [6:0]    lfsr7_q,  lfsr7_d;
    logic [14:0]   lfsr15_q, lfsr15_d;
    logic [DW-1:0] data_d;
    logic          dunf_d;
    logic          mode_chg;

    logic [DW-1:0] dds_beat, pat_beat, pn7_beat, pn15_beat;
    logic [6:0]    pn7_s;
    logic [14:0]   pn15_s;

    assign dma.dma_ready = dma_ready_q;

    // Per-sample DDS format fix-up and alternating pattern beat
    always_comb begin
        dds_beat = '0;
        pat_beat = '0;
        for (int k = 0; k < int'(DATA_PATH_WIDTH); k++) begin
            dds_beat[k*SW +: SW] = dds_data[k*SW +: SW] ^ {dac_dds_format, 15'd0};
            pat_beat[k*SW +: SW] = (k % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
        end
    end

    // Unrolled LFSRs: one output bit per step (the bit shifted out), filling
    // each sample MSB first, sample 0 with the earliest bits.
    always_comb begin
        pn7_s     = lfsr7_q;
        pn15_s    = lfsr15_q;
        pn7_beat  = '0;
        pn15_beat = '0;
        for (int k = 0; k < int'(DATA_PATH_WIDTH); k++) begin
            for (int b = int'(SW) - 1; b >= 0; b--) begin
                pn7_beat[k*SW + b]  = pn7_s[6];
                pn15_beat[k*SW + b] = pn15_s[14];
                pn7_s  = {pn7_s[5:0],   pn7_s[6]   ^ pn7_s[5]};
                pn15_s = {pn15_s[13:0], pn15_s[14] ^ pn15_s[13]};
            end
        end
    end

`ifdef AD_TPL_DAC_SRC_RAMP_EN
    logic [SW-1:0] ramp_q, ramp_d;
    logic [DW-1:0] ramp_beat;

    // Ramp beat: sample k = ramp_q + k, modulo 2^16
    always_comb begin
        ramp_beat = '0;
        for (int k = 0; k < int'(DATA_PATH_WIDTH); k++) begin
            ramp_beat[k*SW +: SW] = ramp_q + 16'(k);
        end
    end
`endif

    // Next-state / output decode; the beat source is chosen by sel_q only,
    // so a select change can never produce a mixed beat.
    always_comb begin
        mode_chg = (dac_data_sel != sel_q);
        data_d   = '0;
        dunf_d   = 1'b0;
        lfsr7_d  = lfsr7_q;
        lfsr15_d = lfsr15_q;
`ifdef AD_TPL_DAC_SRC_RAMP_EN
        ramp_d   = ramp_q;
`endif
        case (sel_q)
            SEL_DDS:  data_d = dds_beat;
            SEL_PAT:  data_d = pat_beat;
            SEL_DMA: begin
                if (dma.dma_valid) begin
                    data_d = dma.dma_data;
                end else begin
                    dunf_d = 1'b1;
                end
            end
            SEL_ZERO: data_d = '0;
            SEL_PN7: begin
                data_d  = pn7_beat;
                lfsr7_d = pn7_s;
            end
            SEL_PN15: begin
                data_d   = pn15_beat;
                lfsr15_d = pn15_s;
            end
`ifdef AD_TPL_DAC_SRC_RAMP_EN
            SEL_RAMP: begin
                data_d = ramp_beat;
                ramp_d = ramp_q + 16'(DATA_PATH_WIDTH);
            end
`endif
            default:  data_d = '0;
        endcase
        // A select change restarts the generators from their seeds
        if (mode_chg) begin
            lfsr7_d  = '1;
            lfsr15_d = '1;
`ifdef AD_TPL_DAC_SRC_RAMP_EN
            ramp_d   = '0;
`endif
        end
    end

    // State and output registers
    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            sel_q       <= SEL_ZERO;
            dma_ready_q <= 1'b0;
            dac_data    <= '0;
            dac_dunf    <= 1'b0;
            lfsr7_q     <= '1;
            lfsr15_q    <= '1;
        end else begin
            sel_q       <= dac_data_sel;
            dma_ready_q <= (dac_data_sel == SEL_DMA);
            dac_data    <= data_d;
            dac_dunf    <= dunf_d;
            lfsr7_q     <= lfsr7_d;
            lfsr15_q    <= lfsr15_d;
        end
    end

`ifdef AD_TPL_DAC_SRC_RAMP_EN
    // Ramp counter
    always_ff @(posedge link_clk or negedge link_resetn) begin
        if (!link_resetn) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv
module tb_ad_ip_jesd204_tpl_dac_channel_src;

    localparam int unsigned DPW = 4;
    localparam int unsigned DW  = 16 * DPW;
    localparam int          PN7_BITS  = 13312;
    localparam int          PN15_BITS = 256;

    logic          link_clk;
    logic          link_resetn;
    logic [3:0]    dac_data_sel;
    logic          dac_dds_format;
    logic [15:0]   dac_pat_data_0;
    logic [15:0]   dac_pat_data_1;
    logic [DW-1:0] dds_data;
    logic [DW-1:0] dac_data;
    logic          dac_dunf;

    int errors;
    int checks;

    bit pn7_bits  [0:PN7_BITS-1];
    bit pn15_bits [0:PN15_BITS-1];

    ad_ip_jesd204_tpl_dac_channel_src_if #(.DATA_PATH_WIDTH(DPW)) dma_if ();

    ad_ip_jesd204_tpl_dac_channel_src #(
        .DATA_PATH_WIDTH      (DPW),
        .CONVERTER_RESOLUTION (16)
    ) dut (
        .link_clk       (link_clk),
        .link_resetn    (link_resetn),
        .dac_data_sel   (dac_data_sel),
        .dac_dds_format (dac_dds_format),
        .dac_pat_data_0 (dac_pat_data_0),
        .dac_pat_data_1 (dac_pat_data_1),
        .dds_data       (dds_data),
        .dma            (dma_if),
        .dac_data       (dac_data),
        .dac_dunf       (dac_dunf)
    );

    initial link_clk = 1'b0;
    always #5 link_clk = ~link_clk;

    task automatic tick();
        @(posedge link_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Beat j of a PN bit stream: 64 consecutive bits, sample 0 first, MSB first
    function automatic logic [63:0] beat7(input int j);
        logic [63:0] r;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 16; b++)
                r[16*k + 15 - b] = pn7_bits[64*j + 16*k + b];
        return r;
    endfunction

    function automatic logic [63:0] beat15(input int j);
        logic [63:0] r;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 16; b++)
                r[16*k + 15 - b] = pn15_bits[64*j + 16*k + b];
        return r;
    endfunction

    initial begin
        errors = 0;
        checks = 0;

        // PN reference streams from the bit recurrences, seeded all-ones
        for (int n = 0; n < PN7_BITS; n++) begin
            if (n < 7) pn7_bits[n] = 1'b1;
            else       pn7_bits[n] = pn7_bits[n-6] ^ pn7_bits[n-7];
        end
        for (int n = 0; n < PN15_BITS; n++) begin
            if (n < 15) pn15_bits[n] = 1'b1;
            else        pn15_bits[n] = pn15_bits[n-14] ^ pn15_bits[n-15];
        end

        // Reset with DMA selected and valid
        link_resetn      = 1'b0;
        dac_data_sel     = 4'd2;
        dac_dds_format   = 1'b0;
        dac_pat_data_0   = 16'h0;
        dac_pat_data_1   = 16'h0;
        dds_data         = '0;
        dma_if.dma_valid = 1'b1;
        dma_if.dma_data  = 64'hCAFE_0000_0000_0001;
        repeat (3) tick();
        chk("rst_data",  dac_data, 64'h0);
        chk("rst_ready", 64'(dma_if.dma_ready), 64'h0);
        chk("rst_dunf",  64'(dac_dunf), 64'h0);
        link_resetn = 1'b1;
        tick();
        chk("rel1_data", dac_data, 64'h0);
        chk("rel1_dunf", 64'(dac_dunf), 64'h0);
        tick();
        chk("rel2_data",  dac_data, 64'hCAFE_0000_0000_0001);
        chk("rel2_ready", 64'(dma_if.dma_ready), 64'h1);

        // Pattern
        dac_data_sel   = 4'd1;
        dac_pat_data_0 = 16'h1234;
        dac_pat_data_1 = 16'hABCD;
        tick();
        chk("pat_prev", dac_data, 64'hCAFE_0000_0000_0001);
        tick();
        chk("pat", dac_data, 64'hABCD_1234_ABCD_1234);

        // DMA stream with underflow
        dac_data_sel     = 4'd2;
        dma_if.dma_valid = 1'b1;
        dma_if.dma_data  = 64'h1111_2222_3333_4444;
        tick();
        chk("dma_prev", dac_data, 64'hABCD_1234_ABCD_1234);
        tick();
        chk("dma_d0", dac_data, 64'h1111_2222_3333_4444);
        chk("dma_d0_dunf", 64'(dac_dunf), 64'h0);
        dma_if.dma_data = 64'h5555_6666_7777_8888;
        tick();
        chk("dma_d1", dac_data, 64'h5555_6666_7777_8888);
        dma_if.dma_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unf_data", dac_data, 64'h0);
            chk("unf_dunf", 64'(dac_dunf), 64'h1);
        end
        dma_if.dma_valid = 1'b1;
        dma_if.dma_data  = 64'hDEAD_BEEF_0BAD_F00D;
        dac_data_sel     = 4'd3;
        tick();
        chk("dma_d2", dac_data, 64'hDEAD_BEEF_0BAD_F00D);
        chk("dma_d2_dunf", 64'(dac_dunf), 64'h0);
        chk("leave_ready", 64'(dma_if.dma_ready), 64'h0);
        tick();
        chk("zero_data", dac_data, 64'h0);
        chk("zero_dunf", 64'(dac_dunf), 64'h0);
        dma_if.dma_valid = 1'b0;

        // DDS with and without MSB inversion
        dac_data_sel   = 4'd0;
        dac_dds_format = 1'b1;
        dds_data       = 64'h7FFF_8000_1234_0001;
        tick();
        tick();
        chk("dds_fmt1", dac_data, 64'hFFFF_0000_9234_8001);
        dac_dds_format = 1'b0;
        tick();
        chk("dds_fmt0", dac_data, 64'h7FFF_8000_1234_0001);

        // PN7 for 200 beats
        dac_data_sel = 4'd4;
        tick();
        chk("pn7_prev", dac_data, 64'h7FFF_8000_1234_0001);
        tick();
        chk("pn7_seed_s0", 64'(dac_data[15:0]), 64'h0000_0000_0000_FE04);
        chk("pn7_b0", dac_data, beat7(0));
        for (int j = 1; j < 200; j++) begin
            tick();
            chk("pn7_beat", dac_data, beat7(j));
        end

        // PN15 then back to PN7
        dac_data_sel = 4'd5;
        tick();
        chk("pn7_b200", dac_data, beat7(200));
        tick();
        chk("pn15_seed_s0", 64'(dac_data[15:0]), 64'h0000_0000_0000_FFFE);
        chk("pn15_b0", dac_data, beat15(0));
        dac_data_sel = 4'd4;
        tick();
        chk("pn15_b1", dac_data, beat15(1));
        tick();
        chk("pn7_restart_b0", dac_data, beat7(0));
        tick();
        chk("pn7_restart_b1", dac_data, beat7(1));

        // Unused select code
        dac_data_sel = 4'd7;
        tick();
        chk("pn7_restart_b2", dac_data, beat7(2));
        tick();
        chk("code7_zero", dac_data, 64'h0);

        // Ramp
        dac_data_sel = 4'd11;
        tick();
        chk("ramp_prev", dac_data, 64'h0);
        tick();
`ifdef AD_TPL_DAC_SRC_RAMP_EN
        chk("ramp_b0", dac_data, 64'h0003_0002_0001_0000);
        tick();
        chk("ramp_b1", dac_data, 64'h0007_0006_0005_0004);
        repeat (16382) tick();
        chk("ramp_b16383", dac_data, 64'hFFFF_FFFE_FFFD_FFFC);
        tick();
        chk("ramp_wrap", dac_data, 64'h0003_0002_0001_0000);
`else
        chk("ramp_off_b0", dac_data, 64'h0);
        tick();
        chk("ramp_off_b1", dac_data, 64'h0);
`endif

        // Reset asserted mid-stream
        dac_data_sel     = 4'd2;
        dma_if.dma_valid = 1'b1;
        dma_if.dma_data  = 64'h0F0F_1E1E_2D2D_3C3C;
        tick();
        tick();
        chk("mid_dma", dac_data, 64'h0F0F_1E1E_2D2D_3C3C);
        chk("mid_ready", 64'(dma_if.dma_ready), 64'h1);
        link_resetn = 1'b0;
        #2;
        chk("mid_rst_data",  dac_data, 64'h0);
        chk("mid_rst_ready", 64'(dma_if.dma_ready), 64'h0);
        chk("mid_rst_dunf",  64'(dac_dunf), 64'h0);
        tick();
        chk("mid_rst_hold", dac_data, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
